// File: rtl/skel_pkg.sv
// Shared types for the thinning kernel: processing modes, FSM states
// and the width of a directional Moravec energy.
package skel_pkg;

    typedef enum logic [1:0] {
        MODE_PASS             = 2'd0,
        MODE_THIN             = 2'd1,
        MODE_THIN_KEEP_CORNER = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_e;

    function automatic int energy_w(input int pw);
        return 2 * pw + 1;
    endfunction

endpackage

// File: rtl/moravec_energy.sv
// One directional Moravec energy, (c-a)^2 + (c-b)^2, registered in stage 1
// and frozen by the stage-1 enable.
module moravec_energy
    import skel_pkg::*;
#(
    parameter int PW = 8,
    localparam int EW = energy_w(PW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [PW-1:0] c,
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [EW-1:0] energy
);

    logic [PW-1:0]   da;
    logic [PW-1:0]   db;
    logic [2*PW-1:0] sa;
    logic [2*PW-1:0] sb;

    always_comb begin
        da = (c > a) ? c - a : a - c;
        db = (c > b) ? c - b : b - c;
        sa = {{PW{1'b0}}, da} * {{PW{1'b0}}, da};
        sb = {{PW{1'b0}}, db} * {{PW{1'b0}}, db};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            energy <= '0;
        end else if (en) begin
            energy <= {1'b0, sa} + {1'b0, sb};
        end
    end

endmodule

// File: rtl/kernel_window_stream.sv
// Raster-stream 3x3 window builder with border / corner thinning decision;
// two line buffers, a 2-stage pipeline and valid/ready on both sides.
module kernel_window_stream
    import skel_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int PW        = 8,
    parameter int BORDER_TH = 1,
    parameter int CORNER_TH = 0,
    localparam int CW = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic          out_last,
    output logic [CW-1:0] corner_cnt,
    output logic          frame_done
);

    localparam int RW = $clog2(IMG_H + 2);
    localparam int XW = $clog2(IMG_W);
    localparam int EW = energy_w(PW);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] R_END  = RW'(IMG_H + 1);
    localparam logic [XW-1:0] C_LAST = XW'(IMG_W - 1);
    localparam logic [PW:0]   B_TH   = (PW + 1)'(BORDER_TH);
    localparam logic [EW-1:0] C_TH   = EW'(CORNER_TH);

    state_e state, state_n;
    logic [RW-1:0] row, cur_row, o_row;
    logic [XW-1:0] col, cur_col, o_col;
    logic [1:0]    mode_q;
    logic          stall, acc, sof_acc, inj, shift;
    logic          produce, edge_n, last_n;
    logic [PW-1:0] pix, top_rd, mid_rd;
    logic [PW-1:0] lb_top [IMG_W];
    logic [PW-1:0] lb_mid [IMG_W];
    logic [PW-1:0] t1, t2, m0, m1, m2, b1, b2;
    logic          s1_valid, s1_edge, s1_last;
    logic [EW-1:0] e_h, e_v, e_d, e_a, emin;
    logic [PW-1:0] nb [5];
    logic [PW-1:0] mx, mn, dout;
    logic          border, corner, thin, hit;
    logic [CW-1:0] cnt_q;

    assign stall      = out_valid & ~out_ready;
    assign acc        = in_valid & in_ready;
    assign sof_acc    = acc & in_sof;
    assign shift      = sof_acc | (acc & (state != IDLE)) | inj;
    assign frame_done = out_valid & out_ready & out_last;
    assign cur_row    = sof_acc ? '0 : row;
    assign cur_col    = sof_acc ? '0 : col;
    assign pix        = inj ? '0 : in_data;
    assign top_rd     = lb_top[cur_col];
    assign mid_rd     = lb_mid[cur_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (sof_acc) state_n = FILL;
            FILL, RUN: begin
                if (sof_acc) begin
                    state_n = FILL;
                end else if (acc && cur_row == R_LAST && cur_col == C_LAST) begin
                    state_n = DRAIN;
                end else if (acc && cur_row == RW'(1) && cur_col == '0) begin
                    state_n = RUN;
                end
            end
            DRAIN: if (frame_done) state_n = IDLE;
        endcase
    end

    // Drain injects zeros until the position passes (IMG_H+1, 0).
    always_comb begin
        in_ready = ~rst & (state != DRAIN) & ~stall;
        inj      = (state == DRAIN) & ~stall & ~(row == R_END && col != '0);
    end

    // Output position is always the input position minus (IMG_W+1).
    always_comb begin
        o_row = cur_row - RW'(1);
        o_col = cur_col - XW'(1);
        if (cur_col == '0) begin
            o_row = cur_row - RW'(2);
            o_col = C_LAST;
        end
        produce = (cur_row >= RW'(2)) || (cur_row == RW'(1) && cur_col != '0);
        edge_n  = (o_row == '0) || (o_row == R_LAST) ||
                  (o_col == '0) || (o_col == C_LAST);
        last_n  = (o_row == R_LAST) && (o_col == C_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            mode_q <= '0;
        end else begin
            if (sof_acc) mode_q <= mode;
            if (shift) begin
                if (cur_col == C_LAST) begin
                    col <= '0;
                    row <= cur_row + RW'(1);
                end else begin
                    col <= cur_col + XW'(1);
                    row <= cur_row;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            lb_top[cur_col] <= mid_rd;
            lb_mid[cur_col] <= pix;
            t1 <= t2;
            t2 <= top_rd;
            m0 <= m1;
            m1 <= m2;
            m2 <= mid_rd;
            b1 <= b2;
            b2 <= pix;
        end
    end

    moravec_energy #(.PW(PW)) u_e_h (
        .clk(clk), .rst(rst), .en(shift),
        .c(m2), .a(m1), .b(mid_rd), .energy(e_h)
    );
    moravec_energy #(.PW(PW)) u_e_v (
        .clk(clk), .rst(rst), .en(shift),
        .c(m2), .a(t2), .b(b2), .energy(e_v)
    );
    moravec_energy #(.PW(PW)) u_e_d (
        .clk(clk), .rst(rst), .en(shift),
        .c(m2), .a(t1), .b(pix), .energy(e_d)
    );
    moravec_energy #(.PW(PW)) u_e_a (
        .clk(clk), .rst(rst), .en(shift),
        .c(m2), .a(top_rd), .b(b1), .energy(e_a)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_edge  <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            if (!stall) s1_valid <= shift & produce;
            if (shift) begin
                s1_edge <= edge_n;
                s1_last <= last_n;
            end
        end
    end

    always_comb begin
        nb[0] = t1;
        nb[1] = m0;
        nb[2] = m1;
        nb[3] = m2;
        nb[4] = b1;
        mx = nb[0];
        mn = nb[0];
        for (int i = 1; i < 5; i++) begin
            if (nb[i] > mx) mx = nb[i];
            if (nb[i] < mn) mn = nb[i];
        end
        emin = e_h;
        if (e_v < emin) emin = e_v;
        if (e_d < emin) emin = e_d;
        if (e_a < emin) emin = e_a;
        border = {1'b0, mx - mn} >= B_TH;
        corner = emin > C_TH;
        thin   = ~s1_edge & border &
                 ((mode_q == MODE_THIN) |
                  ((mode_q == MODE_THIN_KEEP_CORNER) & ~corner));
        dout   = thin ? '0 : m1;
        hit    = s1_valid & ~s1_edge & border & corner &
                 (mode_q == MODE_THIN_KEEP_CORNER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            cnt_q      <= '0;
            corner_cnt <= '0;
        end else begin
            if (sof_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                cnt_q     <= '0;
            end else if (!stall) begin
                out_valid <= s1_valid;
                out_data  <= dout;
                out_last  <= s1_valid & s1_last;
                if (hit) cnt_q <= cnt_q + CW'(1);
            end
            if (frame_done) corner_cnt <= cnt_q;
        end
    end

endmodule
